// File: rtl/unary_pkg.sv
// Shared types and elaboration-time helpers for the multi-lane unary adder.
package unary_pkg;

   typedef enum logic {ACCUM = 1'b0, EMIT = 1'b1} state_t;

   // Ceiling log2; a value of 1 still needs one bit.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++)
         if ((32'd1 << i) < v) r = i + 1;
      if (r == 0) r = 1;
      return r;
   endfunction

   function automatic int unsigned frame_len(input int unsigned w);
      return 32'd1 << w;
   endfunction

   function automatic int unsigned popcount(input logic [15:0] v, input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 16; i++)
         if (i < n && v[i]) r++;
      return r;
   endfunction

endpackage

// File: rtl/unary_popcount.sv
// Combinational ones counter over N_IN unary lanes.
module unary_popcount
   import unary_pkg::*;
#(
   parameter int unsigned N_IN = 2
) (
   input  logic [N_IN-1:0]              lanes,
   output logic [clog2(N_IN+1)-1:0]     ones
);

   localparam int unsigned OW = clog2(N_IN + 1);

   always_comb begin
      ones = OW'(popcount(16'(lanes), N_IN));
   end

endmodule

// File: rtl/unary_add_multi.sv
// Accumulates N_IN unary lanes into a CNT_W-bit count and serialises it as a thermometer frame.
module unary_add_multi
   import unary_pkg::*;
#(
   parameter int unsigned N_IN     = 2,
   parameter int unsigned CNT_W    = 4,
   parameter bit          SATURATE = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clr,
   input  logic              read_or_write,
   input  logic [N_IN-1:0]   a_in,
   output logic              dout,
   output logic              C,
   output logic [CNT_W-1:0]  count,
   output logic              busy,
   output logic              frame_done
);

   localparam int unsigned         PW       = clog2(N_IN + 1);
   localparam int unsigned         SW       = CNT_W + PW;
   localparam int unsigned         FRAME    = frame_len(CNT_W);
   localparam logic [CNT_W-1:0]    CMAX     = '1;
   localparam logic [CNT_W-1:0]    IDX_LAST = CNT_W'(FRAME - 1);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  count_q, count_nxt;
   logic [CNT_W-1:0]  lat_q, lat_nxt;
   logic [CNT_W-1:0]  idx_q, idx_nxt;
   logic              c_q, c_nxt;
   logic              dout_q, dout_nxt;
   logic              busy_q, busy_nxt;
   logic              fd_q, fd_nxt;
   logic [PW-1:0]     ones;
   logic [SW-1:0]     sum;
   logic              last;

   unary_popcount #(.N_IN(N_IN)) u_popcount (
      .lanes (a_in),
      .ones  (ones)
   );

   assign sum  = SW'(count_q) + SW'(ones);
   assign last = (idx_q == IDX_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  state <= ACCUM;
      else if (en) state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM:   if (read_or_write) state_nxt = EMIT;
         EMIT:    if (last) state_nxt = read_or_write ? EMIT : ACCUM;
         default: state_nxt = ACCUM;
      endcase
   end

   // dout/busy/frame_done are registered, so their next values track the index being entered.
   always_comb begin
      count_nxt = count_q;
      c_nxt     = c_q;
      lat_nxt   = lat_q;
      idx_nxt   = idx_q;
      dout_nxt  = 1'b0;
      busy_nxt  = 1'b0;
      fd_nxt    = 1'b0;
      case (state)
         ACCUM: begin
            if (clr) begin
               count_nxt = '0;
               c_nxt     = 1'b0;
            end
            if (read_or_write) begin
               lat_nxt  = clr ? '0 : count_q;
               idx_nxt  = '0;
               busy_nxt = 1'b1;
               dout_nxt = (lat_nxt != '0);
            end else if (!clr) begin
               if (sum > SW'(CMAX)) begin
                  c_nxt     = 1'b1;
                  count_nxt = SATURATE ? CMAX : sum[CNT_W-1:0];
               end else begin
                  count_nxt = sum[CNT_W-1:0];
               end
            end
         end
         EMIT: begin
            if (last) begin
               count_nxt = '0;
               c_nxt     = 1'b0;
               if (read_or_write) begin
                  lat_nxt  = '0;
                  idx_nxt  = '0;
                  busy_nxt = 1'b1;
               end
            end else begin
               idx_nxt  = idx_q + 1'b1;
               busy_nxt = 1'b1;
               dout_nxt = (idx_nxt < lat_q);
               fd_nxt   = (idx_nxt == IDX_LAST);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         c_q     <= 1'b0;
         lat_q   <= '0;
         idx_q   <= '0;
         dout_q  <= 1'b0;
         busy_q  <= 1'b0;
         fd_q    <= 1'b0;
      end else if (en) begin
         count_q <= count_nxt;
         c_q     <= c_nxt;
         lat_q   <= lat_nxt;
         idx_q   <= idx_nxt;
         dout_q  <= dout_nxt;
         busy_q  <= busy_nxt;
         fd_q    <= fd_nxt;
      end
   end

   assign dout       = dout_q;
   assign C          = c_q;
   assign count      = count_q;
   assign busy       = busy_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_unary_add_multi.sv
// Directed bench: saturating and wrapping instances driven with identical stimulus.
module tb_unary_add_multi;

   logic       clk = 1'b0;
   logic       rst_n, en, clr, read_or_write;
   logic [1:0] a_in;
   logic       dout_s, c_s, busy_s, fd_s;
   logic       dout_w, c_w, busy_w, fd_w;
   logic [3:0] count_s, count_w;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   unary_add_multi #(.N_IN(2), .CNT_W(4), .SATURATE(1'b1)) dut_s (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .read_or_write(read_or_write),
      .a_in(a_in), .dout(dout_s), .C(c_s), .count(count_s), .busy(busy_s), .frame_done(fd_s)
   );

   unary_add_multi #(.N_IN(2), .CNT_W(4), .SATURATE(1'b0)) dut_w (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .read_or_write(read_or_write),
      .a_in(a_in), .dout(dout_w), .C(c_w), .count(count_w), .busy(busy_w), .frame_done(fd_w)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b1; en = 1'b0; clr = 1'b0; read_or_write = 1'b0; a_in = 2'b00;
      #2 rst_n = 1'b0;
      cyc(); cyc();
      check("rst_count", 32'(count_s), 0);
      check("rst_c", 32'(c_s), 0);
      check("rst_dout", 32'(dout_s), 0);
      check("rst_busy", 32'(busy_s), 0);
      check("rst_fd", 32'(fd_s), 0);
      check("rst_count_w", 32'(count_w), 0);
      rst_n = 1'b1; en = 1'b1;

      // 19 cycles of two ones each: 38 -> clamps at 15 / wraps to 6
      a_in = 2'b11;
      for (int i = 0; i < 19; i++) cyc();
      check("sat_count", 32'(count_s), 15);
      check("sat_c", 32'(c_s), 1);
      check("wrap_count", 32'(count_w), 6);
      check("wrap_c", 32'(c_w), 1);
      read_or_write = 1'b1;
      cyc();
      read_or_write = 1'b0; a_in = 2'b00;
      for (int k = 0; k < 16; k++) begin
         check("sat_dout", 32'(dout_s), 32'(k < 15));
         check("wrap_dout", 32'(dout_w), 32'(k < 6));
         check("sat_busy", 32'(busy_s), 1);
         check("sat_fd", 32'(fd_s), 32'(k == 15));
         check("wrap_fd", 32'(fd_w), 32'(k == 15));
         cyc();
      end
      check("post_busy", 32'(busy_s), 0);
      check("post_count", 32'(count_s), 0);
      check("post_c", 32'(c_s), 0);
      check("post_c_w", 32'(c_w), 0);
      check("post_dout", 32'(dout_s), 0);

      // mixed lane patterns totalling 4, with an en gap mid-frame
      a_in = 2'b01; cyc();
      a_in = 2'b10; cyc();
      a_in = 2'b00; cyc();
      a_in = 2'b11; cyc();
      check("mix_count", 32'(count_s), 4);
      check("mix_c", 32'(c_s), 0);
      read_or_write = 1'b1; a_in = 2'b00;
      cyc();
      read_or_write = 1'b0;
      for (int k = 0; k < 16; k++) begin
         check("mix_dout", 32'(dout_s), 32'(k < 4));
         check("mix_busy", 32'(busy_s), 1);
         check("mix_fd", 32'(fd_s), 32'(k == 15));
         if (k == 2) begin
            en = 1'b0;
            for (int j = 0; j < 5; j++) begin
               cyc();
               check("hold_dout", 32'(dout_s), 1);
               check("hold_busy", 32'(busy_s), 1);
            end
            en = 1'b1;
         end
         cyc();
      end
      check("mix_busy_end", 32'(busy_s), 0);

      // async reset mid-frame
      a_in = 2'b11;
      for (int i = 0; i < 3; i++) cyc();
      check("pre_rst_count", 32'(count_s), 6);
      read_or_write = 1'b1; a_in = 2'b00;
      cyc();
      read_or_write = 1'b0;
      cyc(); cyc(); cyc();
      check("pre_rst_dout", 32'(dout_s), 1);
      check("pre_rst_busy", 32'(busy_s), 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_dout", 32'(dout_s), 0);
      check("mid_rst_busy", 32'(busy_s), 0);
      check("mid_rst_count", 32'(count_s), 0);
      cyc();
      rst_n = 1'b1;

      // clr beats accumulation in ACCUM
      a_in = 2'b11;
      for (int i = 0; i < 9; i++) cyc();
      check("clr_pre_c", 32'(c_s), 1);
      check("clr_pre_count_w", 32'(count_w), 2);
      clr = 1'b1;
      cyc();
      check("clr_count", 32'(count_s), 0);
      check("clr_c", 32'(c_s), 0);
      check("clr_count_w", 32'(count_w), 0);
      check("clr_c_w", 32'(c_w), 0);
      clr = 1'b0;

      // clr held throughout a frame is ignored
      cyc(); cyc();
      check("eclr_count", 32'(count_s), 4);
      read_or_write = 1'b1; a_in = 2'b00;
      cyc();
      read_or_write = 1'b0; clr = 1'b1;
      for (int k = 0; k < 16; k++) begin
         check("eclr_dout", 32'(dout_s), 32'(k < 4));
         check("eclr_fd", 32'(fd_s), 32'(k == 15));
         cyc();
      end
      clr = 1'b0;
      check("eclr_busy_end", 32'(busy_s), 0);

      // continuous emission: second frame is all zeros
      a_in = 2'b01;
      for (int i = 0; i < 3; i++) cyc();
      check("cont_count", 32'(count_s), 3);
      read_or_write = 1'b1; a_in = 2'b00;
      cyc();
      for (int k = 0; k < 32; k++) begin
         check("cont_dout", 32'(dout_s), 32'(k < 3));
         check("cont_fd", 32'(fd_s), 32'(k == 15 || k == 31));
         check("cont_busy", 32'(busy_s), 1);
         if (k == 31) read_or_write = 1'b0;
         cyc();
      end
      check("cont_busy_end", 32'(busy_s), 0);
      check("cont_fd_end", 32'(fd_s), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/unary_add_multi.md
Name: unary_add_multi

Overview:
- Parametrised successor of the single-lane unary adder.
- Accumulates N_IN parallel 1-bit unary streams into one CNT_W-bit count.
- Flags overflow, with selectable saturate or wrap.
- On command, serialises the count as a thermometer-coded frame of fixed length 2^CNT_W on dout.
- Sits between unary stream sources and downstream unary consumers or comparators.

Parameters:
N_IN, 2, number of parallel unary input lanes (1..16)
CNT_W, 4, accumulator width; frame length FRAME = 2^CNT_W cycles
SATURATE, 1, 1 = clamp at 2^CNT_W-1 on overflow; 0 = wrap modulo 2^CNT_W

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  clock enable; 0 freezes all state and outputs
clr  in  1  synchronous clear of count and C (effective only when en=1)
read_or_write  in  1  0 = accumulate (read), 1 = request emission (write)
a_in  in  N_IN  unary input lanes, one bit per lane per cycle
dout  out  1  thermometer-coded serial output, registered
C  out  1  sticky overflow flag, registered
count  out  CNT_W  current accumulator value
busy  out  1  high while a frame is being emitted
frame_done  out  1  one-cycle pulse on the last bit of a frame

Behaviour:
- Reset (async, rst_n=0): state=ACCUM, count=0, C=0, dout=0, busy=0, frame_done=0, emit index=0.
- All updates happen only when en=1. With en=0, every register holds, including mid-frame.
- State ACCUM:
  - Each cycle with read_or_write=0: sum = count + popcount(a_in), computed CNT_W+clog2(N_IN+1) wide.
  - sum <= 2^CNT_W-1: count=sum.
  - Otherwise C is set to 1 (sticky). SATURATE=1 gives count = 2^CNT_W-1; SATURATE=0 gives count = sum mod 2^CNT_W.
  - dout=0 throughout ACCUM.
- ACCUM -> EMIT: on any cycle with read_or_write=1 sampled. That cycle's a_in is ignored. The count is latched into the emit register and the index is set to 0.
- State EMIT:
  - busy=1.
  - On each cycle, dout = (index < latched count).
  - Index increments each enabled cycle.
  - First dout bit is valid on the cycle after the transition edge, i.e. 1-cycle latency.
  - A frame is exactly FRAME cycles: latched count ones, followed by FRAME-count zeros.
- Frame end:
  - On the cycle where index = FRAME-1, frame_done=1.
  - The next state is ACCUM with count=0 and C=0.
  - busy drops on the following cycle.
- If read_or_write is still 1 at frame end, a new frame starts immediately, emitting the now-zero count as FRAME zeros. frame_done pulses again. This mode is continuous emission.
- read_or_write falling during EMIT is ignored; the frame always completes.
- clr:
  - In ACCUM, clr clears count and C, and has priority over accumulation in the same cycle.
  - In EMIT, clr is ignored.
- Count = 0 emits an all-zero frame. Count = 2^CNT_W-1 emits FRAME-1 ones then a single zero.
- Reset asserted mid-frame aborts immediately, with all outputs going to reset values.

Decomposition:
- Shared package unary_pkg holds:
  - state enum {ACCUM, EMIT};
  - function popcount(N_IN);
  - function clog2;
  - constant FRAME derivation.
- One sub-module is natural: unary_popcount, a combinational N_IN-input ones counter with output width clog2(N_IN+1). The top block holds the FSM, accumulator, overflow logic and emit counter.

Test Plan:
- N_IN=2, CNT_W=4, SATURATE=1. Apply a_in=2'b11 for 19 cycles, then read_or_write=1.
  - Required: count=15, C=1.
  - dout gives 15 ones then 1 zero, with frame_done on the 16th emit cycle.
  - count=0 and C=0 after the frame.
- Same stimulus with SATURATE=0.
  - Required: C=1 and count = 38 mod 16 = 6.
  - dout gives 6 ones then 10 zeros.
- Apply a_in=2'b01, then 2'b10, then 2'b00, then 2'b11, then read_or_write=1.
  - Required: count=4, C=0.
  - dout gives 4 ones then 12 zeros, and busy is high for 16 cycles.
- Mid-frame, drop en for 5 cycles.
  - Required: dout and index are held, and the frame resumes with the correct total of ones.
  - Separately, assert rst_n=0 mid-frame. Required: dout=0, busy=0, count=0 at once.
- clr=1 together with a_in=2'b11 in ACCUM.
  - Required: count=0 and C=0 next cycle.
  - Separately, clr during EMIT has no effect on the frame.
- Hold read_or_write=1 across a frame boundary.
  - Required: a second frame of 16 zeros follows.
  - frame_done pulses twice, 16 cycles apart.
